spi_master_gen: RTL and testbench

- Parametrised SPI master. Successor to the fixed 16-bit mode-0 transmit-only SPI FSM.
- Adds configurable word width, clock divider, all four SPI modes (selected at run time) and multiple chip selects.
- Adds full-duplex MISO capture and a start/busy/done handshake for a host-side controller.
- Sits between an on-chip command sequencer and off-chip SPI peripherals.

---
 rtl/spi_master_gen.sv | 165 ++++++++++++++++
 tb/tb_spi_master_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable width, divider, run-time mode and chip selects,
// full-duplex shift with a start/busy/done handshake.
module spi_master_gen #(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 25,
    parameter int NUM_CS   = 1,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_CS-1:0] CS_N
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD);
    localparam logic [CS_W:0]     NUM_CS_V   = (CS_W + 1)'(NUM_CS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [NUM_CS-1:0]   r_cs_n;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_mosi;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rx_data;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic [PH_W-1:0]     r_ph_cnt;

    logic [NUM_CS-1:0]   w_cs_dec;
    logic                w_cs_ok;
    logic                w_tick;
    logic                w_leading;
    logic                w_last;
    logic                w_shift_out;
    logic                w_sample;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = (cs_sel == CS_W'(gi));
        end
    endgenerate

    assign w_cs_ok   = ({1'b0, cs_sel} < NUM_CS_V);
    assign w_tick    = (r_state == S_XFER) && (r_div_cnt == DIV_LAST);
    // Even edge count means the upcoming edge is a leading one (1st, 3rd, ...).
    assign w_leading = ~r_edge_cnt[0];
    assign w_last    = (r_edge_cnt == EDGE_LAST);
    // CPHA=0 already drove the MSB during SETUP, so it skips the shift on the final trailing edge.
    assign w_shift_out = w_tick && (r_mode[0] ? w_leading : (!w_leading && !w_last));
    assign w_sample    = w_tick && (r_mode[0] ? !w_leading : w_leading);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'b00;
            r_cs_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ph_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= r_mode[1];
                    if (start && w_cs_ok) begin
                        r_mode     <= mode;
                        r_cs_n     <= ~w_cs_dec;
                        r_busy     <= 1'b1;
                        r_sclk     <= mode[1];
                        r_mosi     <= mode[0] ? 1'b0 : tx_data[DATA_W-1];
                        r_tx_shift <= mode[0] ? tx_data : (tx_data << 1);
                        r_rx_shift <= '0;
                        r_ph_cnt   <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_sclk <= r_mode[1];
                    if (r_ph_cnt == SETUP_LAST) begin
                        r_div_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_state    <= S_XFER;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (w_last) begin
                            r_ph_cnt <= '0;
                            r_state  <= S_HOLD;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                    if (w_shift_out) begin
                        r_mosi     <= r_tx_shift[DATA_W-1];
                        r_tx_shift <= r_tx_shift << 1;
                    end
                    if (w_sample) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], MISO};
                    end
                end
                S_HOLD: begin
                    // The final-edge cycle plus CS_HOLD further cycles keep CS_N low.
                    if (r_ph_cnt == HOLD_LAST) begin
                        r_cs_n    <= '1;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx_shift;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign SCLK    = r_sclk;
    assign MOSI    = r_mosi;
    assign CS_N    = r_cs_n;

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: random and directed words, loopback or a behavioural
// SPI peripheral on MISO, and a negedge monitor that checks every completed word.
module tb_spi_master_gen;

    localparam int DW  = 16;
    localparam int DIV = 25;
    localparam int NCS = 5;
    localparam int SET = 2;
    localparam int HLD = 2;
    localparam int CSW = 3;
    localparam int LAT = SET + 2 * DW * DIV + HLD + 1;

    typedef struct packed {
        logic [1:0]     mode;
        logic [NCS-1:0] cs_n;
        logic [DW-1:0]  tx;
        logic [DW-1:0]  rx;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [CSW-1:0] cs_sel = '0;
    logic [DW-1:0]  tx_data = '0;
    logic           busy, done, SCLK, MOSI;
    logic [DW-1:0]  rx_data;
    logic [NCS-1:0] CS_N;

    logic           use_loop = 1'b1;
    logic           miso_slave = 1'b0;
    logic [DW-1:0]  slave_word = '0;
    logic           w_miso;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    assign w_miso = use_loop ? MOSI : miso_slave;

    always #5 clk = ~clk;

    spi_master_gen #(
        .DATA_W(DW), .CLK_DIV(DIV), .NUM_CS(NCS), .CS_SETUP(SET), .CS_HOLD(HLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cs_sel(cs_sel),
        .tx_data(tx_data), .busy(busy), .done(done), .rx_data(rx_data),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(w_miso), .CS_N(CS_N)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int             cyc = 0;
    logic           sclk_prev = 1'b0, mosi_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
    logic           m_active = 1'b0;
    exp_t           m_exp;
    int             m_t0, m_edges = 0, m_last, m_hpmin, m_hpmax, m_glitch, m_idx;
    logic [DW-1:0]  m_cap;
    logic [NCS-1:0] m_cs_seen;
    logic           m_sclk_setup;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active  = 1'b0;
            busy_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) chk("done_pulse_width", done, 0);
            if (busy && !busy_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_busy: got busy=1 with nothing issued, required busy=0");
                end else begin
                    m_exp        = sb[0];
                    m_active     = 1'b1;
                    m_t0         = cyc;
                    m_edges      = 0;
                    m_last       = -1;
                    m_hpmin      = 1000000;
                    m_hpmax      = 0;
                    m_glitch     = 0;
                    m_cap        = '0;
                    m_cs_seen    = CS_N;
                    m_sclk_setup = SCLK;
                end
            end else if (m_active) begin
                if (SCLK != sclk_prev) begin
                    m_edges++;
                    if (m_last >= 0) begin
                        if (cyc - m_last < m_hpmin) m_hpmin = cyc - m_last;
                        if (cyc - m_last > m_hpmax) m_hpmax = cyc - m_last;
                    end
                    m_last = cyc;
                    // Peripheral samples on leading edges for CPHA=0, trailing for CPHA=1.
                    if (m_exp.mode[0] ? (m_edges % 2 == 0) : (m_edges % 2 == 1))
                        m_cap = {m_cap[DW-2:0], mosi_prev};
                end
                if (busy && CS_N != m_cs_seen) m_glitch++;
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0 || !m_active) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 with no transaction pending, required none");
                end else begin
                    m_exp = sb.pop_front();
                    chk("rx_data", rx_data, m_exp.rx);
                    chk("mosi_word", m_cap, m_exp.tx);
                    chk("sclk_edges", m_edges, 2 * DW);
                    chk("latency", cyc - m_t0, LAT);
                    chk("cs_n_active", m_cs_seen, m_exp.cs_n);
                    chk("cs_n_glitch", m_glitch, 0);
                    chk("half_period_min", m_hpmin, DIV);
                    chk("half_period_max", m_hpmax, DIV);
                    chk("sclk_setup_cpol", m_sclk_setup, m_exp.mode[1]);
                    chk("sclk_end_cpol", SCLK, m_exp.mode[1]);
                    chk("cs_n_release", CS_N, {NCS{1'b1}});
                end
                m_active = 1'b0;
            end
            // Peripheral model: present bit m_idx (MSB first) ahead of each sampling edge.
            if (m_active) begin
                if (m_exp.mode[0]) m_idx = (m_edges == 0) ? 0 : (m_edges - 1) / 2;
                else               m_idx = m_edges / 2;
                if (m_idx > DW - 1) m_idx = DW - 1;
                miso_slave = slave_word[DW-1-m_idx];
            end
            busy_prev = busy;
            done_prev = done;
        end
        sclk_prev = SCLK;
        mosi_prev = MOSI;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] m, input int cs, input logic [DW-1:0] tx,
                         input logic loop, input logic [DW-1:0] sw);
        exp_t e;
        use_loop   = loop;
        slave_word = sw;
        mode       = m;
        cs_sel     = CSW'(cs);
        tx_data    = tx;
        e.mode     = m;
        e.cs_n     = ~(NCS'(1) << cs);
        e.tx       = tx;
        e.rx       = loop ? tx : sw;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, done, 1);
        @(negedge clk);
    endtask

    task automatic try_invalid(input int cs);
        mode    = 2'b00;
        cs_sel  = CSW'(cs);
        tx_data = 16'h1234;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("invalid_cs%0d_busy", cs), busy, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        int   saved;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_cs_n", CS_N, {NCS{1'b1}});
        chk("rst_sclk", SCLK, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(2'b00, 0, 16'h10FF, 1'b1, '0);       wait_done("mode0_10ff");
        issue(2'b11, 0, 16'hA5C3, 1'b0, 16'h3C5A); wait_done("mode3_a5c3");
        chk("idle_sclk_cpol1", SCLK, 1);
        issue(2'b01, 0, 16'h8001, 1'b1, '0);       wait_done("mode1_8001");
        issue(2'b10, 0, 16'h8001, 1'b1, '0);       wait_done("mode2_8001");
        issue(2'b00, 2, DW'($urandom), 1'b1, '0);  wait_done("cs2");

        try_invalid(5);
        try_invalid(7);

        // Second start mid-XFER with different fields must be ignored.
        issue(2'b00, 1, 16'h5A0F, 1'b1, '0);
        repeat (300) @(negedge clk);
        start   = 1'b1;
        tx_data = 16'hFFFF;
        mode    = 2'b11;
        cs_sel  = 3'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("mid_start");

        // Back-to-back: start held through done.
        use_loop = 1'b1;
        mode = 2'b00; cs_sel = 3'd3; tx_data = 16'hC0DE;
        e = '{mode: 2'b00, cs_n: ~(NCS'(1) << 3), tx: 16'hC0DE, rx: 16'hC0DE};
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        mode = 2'b01; cs_sel = 3'd4; tx_data = 16'h0BAD;
        e = '{mode: 2'b01, cs_n: ~(NCS'(1) << 4), tx: 16'h0BAD, rx: 16'h0BAD};
        sb.push_back(e);
        wait_done("b2b_first");
        chk("b2b_second_accepted", busy, 1);
        start = 1'b0;
        wait_done("b2b_second");

        for (int k = 0; k < 8; k++) begin
            issue(2'($urandom_range(0, 3)), $urandom_range(0, NCS - 1), DW'($urandom),
                  1'($urandom_range(0, 1)), DW'($urandom));
            wait_done($sformatf("rand%0d", k));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Asynchronous abort around bit 7.
        issue(2'b11, 2, DW'($urandom), 1'b1, '0);
        for (int i = 0; i < 1000 && m_edges < 14; i++) @(negedge clk);
        chk("abort_reached_bit7", (m_edges >= 14), 1);
        saved = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", CS_N, {NCS{1'b1}});
        chk("abort_sclk", SCLK, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rx_data", rx_data, 0);
        void'(sb.pop_front());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt, saved);

        issue(2'b00, 1, 16'h6E21, 1'b1, '0); wait_done("after_abort");

        repeat (5) @(negedge clk);
        chk("queue_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
